// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive and transmit paths.
// Holds the rx FSM state type, legal oversample ratios and small helpers.
package uart_pkg;

    localparam int RX_DATA_WIDTH     = 8;
    localparam int RX_PRESCALE_WIDTH = 6;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic is_legal_prescale(input int p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: line/config inputs and byte/strobe outputs of the rx engine.
// slave is the receiver's view, master the system controller's view.
interface uart_rx_core_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);

    logic                      rx_sync;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      par_en;
    logic                      par_typ;
    logic [DATA_WIDTH-1:0]     rx_data;
    logic                      data_valid;
    logic                      par_err;
    logic                      stop_err;
    logic                      busy;

    modport slave (
        input  rx_sync,
        input  prescale,
        input  par_en,
        input  par_typ,
        output rx_data,
        output data_valid,
        output par_err,
        output stop_err,
        output busy
    );

    modport master (
        output rx_sync,
        output prescale,
        output par_en,
        output par_typ,
        input  rx_data,
        input  data_valid,
        input  par_err,
        input  stop_err,
        input  busy
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter, 3-point capture and majority vote.
// The vote is combinational on the third sample so the FSM can act that edge.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_WIDTH = RX_PRESCALE_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_run,
    input  logic                      i_rx,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic                      o_bit_value,
    output logic                      o_bit_done,
    output logic                      o_vote_ready
);

    logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
    logic [PRESCALE_WIDTH-1:0] w_half;
    logic                      r_s0;
    logic                      r_s1;
    logic                      r_bit;
    logic                      w_vote;
    logic                      w_at_s0;
    logic                      w_at_s1;

    assign w_half  = i_prescale >> 1;
    assign w_at_s0 = i_run && (r_edge_cnt == w_half - PRESCALE_WIDTH'(1));
    assign w_at_s1 = i_run && (r_edge_cnt == w_half);

    assign o_vote_ready = i_run && (r_edge_cnt == w_half + PRESCALE_WIDTH'(1));
    assign o_bit_done   = i_run && (r_edge_cnt == i_prescale - PRESCALE_WIDTH'(1));

    assign w_vote      = maj3(r_s0, r_s1, i_rx);
    assign o_bit_value = o_vote_ready ? w_vote : r_bit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_edge_cnt <= '0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_bit      <= 1'b0;
        end else begin
            if (!i_run || o_bit_done) begin
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= r_edge_cnt + PRESCALE_WIDTH'(1);
            end
            if (w_at_s0) begin
                r_s0 <= i_rx;
            end
            if (w_at_s1) begin
                r_s1 <= i_rx;
            end
            if (o_vote_ready) begin
                r_bit <= w_vote;
            end
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receive FSM, deframer, parity check and output strobes.
// Voted serial bits come from uart_rx_sampler; config is frozen per frame.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = RX_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = RX_PRESCALE_WIDTH
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_rx_core_if.slave rx_if
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_t                 r_state;
    rx_state_t                 w_state_nxt;
    logic [PRESCALE_WIDTH-1:0] r_pre;
    logic                      r_par_en;
    logic                      r_par_typ;
    logic                      r_par_bad;
    logic [CW-1:0]             r_bit_cnt;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic [DATA_WIDTH-1:0]     r_data;
    logic                      r_valid;
    logic                      r_perr;
    logic                      r_serr;
    logic                      r_busy;

    logic w_bit;
    logic w_done;
    logic w_ready;
    logic w_run;
    logic w_start;
    logic w_last;
    logic w_par_exp;
    logic w_pre_ok;

    assign w_run     = (r_state != ST_IDLE);
    assign w_start   = (r_state == ST_IDLE) && !rx_if.rx_sync;
    assign w_last    = (r_bit_cnt == CW'(DATA_WIDTH - 1));
    assign w_par_exp = r_par_typ ? ~^r_shift : ^r_shift;
    assign w_pre_ok  = is_legal_prescale(int'(rx_if.prescale));

    uart_rx_sampler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_sampler (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_run        (w_run),
        .i_rx         (rx_if.rx_sync),
        .i_prescale   (r_pre),
        .o_bit_value  (w_bit),
        .o_bit_done   (w_done),
        .o_vote_ready (w_ready)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (!rx_if.rx_sync) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_done) begin
                    w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_done && w_last) begin
                    w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_done) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // leave on the stop vote; the stop tail is absorbed in IDLE
                if (w_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pre     <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_par_bad <= 1'b0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_serr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_serr  <= 1'b0;
            r_busy  <= w_run;
            if (w_start) begin
                // unsupported ratios fall back to 16 so the counter still wraps
                r_pre     <= w_pre_ok ? rx_if.prescale
                                      : PRESCALE_WIDTH'(PRESCALE_16);
                r_par_en  <= rx_if.par_en;
                r_par_typ <= rx_if.par_typ;
                r_par_bad <= 1'b0;
                r_bit_cnt <= '0;
            end
            if ((r_state == ST_DATA) && w_done) begin
                r_shift   <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end
            if ((r_state == ST_PARITY) && w_done) begin
                r_par_bad <= (w_bit != w_par_exp);
            end
            if ((r_state == ST_STOP) && w_ready) begin
                r_serr <= !w_bit;
                r_perr <= r_par_bad;
                if (w_bit && !r_par_bad) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign rx_if.rx_data    = r_data;
    assign rx_if.data_valid = r_valid;
    assign rx_if.par_err    = r_perr;
    assign rx_if.stop_err   = r_serr;
    assign rx_if.busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames against a per-cycle expectation model.
// Frame-level timing and parity rules are computed from bit counts.
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int MAXC = 4096;

    logic clk;
    logic rst;

    uart_rx_core_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) ifc ();

    uart_rx_core #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .rx_if (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = -1;
    bit chk_en = 1'b0;

    bit       exp_valid [MAXC];
    bit       exp_perr  [MAXC];
    bit       exp_serr  [MAXC];
    bit       exp_busy  [MAXC];
    bit [7:0] exp_data  [MAXC];
    bit [7:0] mdl_data = 8'h00;

    int n_valid    = 0;
    int n_perr     = 0;
    int n_serr     = 0;
    int last_valid = -1;
    int last_perr  = -1;
    int last_serr  = -1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d",
                      nm, act, exp, cyc);
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (chk_en && cyc < MAXC) begin
            if (rst) mdl_data = 8'h00;
            else if (exp_valid[cyc]) mdl_data = exp_data[cyc];
            chk("data_valid", ifc.data_valid, exp_valid[cyc]);
            chk("par_err", ifc.par_err, exp_perr[cyc]);
            chk("stop_err", ifc.stop_err, exp_serr[cyc]);
            chk("busy", ifc.busy, exp_busy[cyc]);
            chk("rx_data", ifc.rx_data, mdl_data);
            if (ifc.data_valid === 1'b1) begin n_valid++; last_valid = cyc; end
            if (ifc.par_err === 1'b1) begin n_perr++; last_perr = cyc; end
            if (ifc.stop_err === 1'b1) begin n_serr++; last_serr = cyc; end
        end
    end

    task automatic clear_from(input int c0);
        for (int c = c0; c < MAXC; c++) begin
            exp_valid[c] = 1'b0;
            exp_perr[c]  = 1'b0;
            exp_serr[c]  = 1'b0;
            exp_busy[c]  = 1'b0;
            exp_data[c]  = 8'h00;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ifc.rx_sync = 1'b1;
        end
    endtask

    // model: N bits precede stop, strobe at E + N*P + P/2 + 2, busy E+1..strobe
    task automatic model_frame(input int e, input int p, input bit pe,
                               input bit pt, input bit [7:0] d,
                               input bit pbit, input bit sbit);
        int nb;
        int sc;
        bit pbad;
        nb   = 1 + 8 + int'(pe);
        sc   = e + nb * p + p / 2 + 2;
        pbad = pe && (((($countones(d) + int'(pbit)) % 2) != int'(pt)));
        for (int c = e + 1; c <= sc && c < MAXC; c++) exp_busy[c] = 1'b1;
        if (sc < MAXC) begin
            exp_serr[sc] = !sbit;
            exp_perr[sc] = pbad;
            if (sbit && !pbad) begin
                exp_valid[sc] = 1'b1;
                exp_data[sc]  = d;
            end
        end
    endtask

    task automatic send_frame(input int p, input bit pe, input bit pt,
                              input bit [7:0] d, input bit pbit, input bit sbit,
                              input bit flip, input int abort_b, output int e);
        bit lv [0:10];
        int nb;
        bit v;
        nb = 1 + 8 + int'(pe);
        lv[0] = 1'b0;
        for (int i = 0; i < 8; i++) lv[1 + i] = d[i];
        if (pe) lv[9] = pbit;
        lv[nb] = sbit;
        e = 0;
        for (int b = 0; b <= nb; b++) begin
            for (int k = 0; k < p; k++) begin
                @(negedge clk);
                if (b == 0 && k == 0) begin
                    e = cyc + 1;
                    ifc.prescale = 6'(p);
                    ifc.par_en   = pe;
                    ifc.par_typ  = pt;
                    if (abort_b < 0) model_frame(e, p, pe, pt, d, pbit, sbit);
                    else for (int c = e + 1; c < MAXC; c++) exp_busy[c] = 1'b1;
                end
                if (b == 1 && k == 0) begin
                    ifc.prescale = (p == PRESCALE_8) ? 6'(PRESCALE_16)
                                                     : 6'(PRESCALE_8);
                    ifc.par_en   = !pe;
                    ifc.par_typ  = !pt;
                end
                if (b == abort_b && k == 0) begin
                    ifc.rx_sync = 1'b1;
                    rst = 1'b1;
                    clear_from(cyc + 1);
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
                v = lv[b];
                if (flip && b >= 1 && b <= 8 && k == p / 2 + 1) v = !v;
                if (b == nb && !sbit && k >= p / 2 + 3) v = 1'b1;
                ifc.rx_sync = v;
            end
        end
    endtask

    task automatic glitch(input int p, input int len, output int e);
        @(negedge clk);
        e = cyc + 1;
        ifc.prescale = 6'(p);
        ifc.rx_sync  = 1'b0;
        for (int c = e + 1; c <= e + p && c < MAXC; c++) exp_busy[c] = 1'b1;
        repeat (len - 1) @(negedge clk);
        @(negedge clk);
        ifc.rx_sync = 1'b1;
    endtask

    int e;

    initial begin
        rst          = 1'b0;
        ifc.rx_sync  = 1'b1;
        ifc.prescale = 6'(PRESCALE_8);
        ifc.par_en   = 1'b0;
        ifc.par_typ  = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", ifc.busy, 0);
        chk("rst_valid", ifc.data_valid, 0);
        chk("rst_data", ifc.rx_data, 0);

        send_frame(PRESCALE_8, 0, 0, 8'hA5, 0, 1, 0, -1, e);
        idle(4);
        chk("t1_latency", last_valid - e, 78);
        chk("t1_data", ifc.rx_data, 8'hA5);
        chk("t1_nvalid", n_valid, 1);

        send_frame(PRESCALE_16, 1, 0, 8'h3C, 0, 1, 0, -1, e);
        idle(4);
        chk("t2_latency", last_valid - e, 170);
        chk("t2_data", ifc.rx_data, 8'h3C);
        send_frame(PRESCALE_16, 1, 0, 8'h3C, 1, 1, 0, -1, e);
        idle(4);
        chk("t2_perr_latency", last_perr - e, 170);
        chk("t2_nvalid", n_valid, 2);
        chk("t2_data_kept", ifc.rx_data, 8'h3C);

        send_frame(PRESCALE_32, 0, 0, 8'h96, 0, 0, 0, -1, e);
        idle(4);
        chk("t3_serr_latency", last_serr - e, 306);
        chk("t3_nvalid", n_valid, 2);
        chk("t3_nperr", n_perr, 1);

        glitch(PRESCALE_16, 2, e);
        idle(40);
        chk("t4_nvalid", n_valid, 2);
        chk("t4_nserr", n_serr, 1);

        send_frame(PRESCALE_8, 0, 0, 8'h5A, 0, 1, 1, -1, e);
        idle(2);
        chk("t5_vote_data", ifc.rx_data, 8'h5A);
        send_frame(PRESCALE_8, 0, 0, 8'h01, 0, 1, 0, -1, e);
        send_frame(PRESCALE_8, 0, 0, 8'hFE, 0, 1, 0, -1, e);
        idle(4);
        chk("t5_b2b_latency", last_valid - e, 78);
        chk("t5_nvalid", n_valid, 5);
        chk("t5_data", ifc.rx_data, 8'hFE);

        send_frame(PRESCALE_16, 0, 0, 8'h99, 0, 1, 0, 4, e);
        chk("t6_rst_data", ifc.rx_data, 0);
        chk("t6_rst_busy", ifc.busy, 0);
        idle(6);
        send_frame(PRESCALE_8, 1, 1, 8'h77, 1, 1, 0, -1, e);
        idle(4);
        chk("t6_latency", last_valid - e, 86);
        chk("t6_data", ifc.rx_data, 8'h77);
        chk("t6_nvalid", n_valid, 6);
        chk("t6_nperr", n_perr, 1);
        chk("cycle_budget", cyc < MAXC, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
